// File: rtl/alu_flag_unit.sv
// Handshaked ALU with registered result, architectural NZCV flag register
// and an iterative shift-add multiplier (low WIDTH bits, unsigned).
module alu_flag_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_OP,
  input  logic             S,
  input  logic             mul,
  input  logic             shiftCout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             wr_en,
  output logic [3:0]       NZCV,
  output logic             busy
);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             mul_s;

  logic             accept_c;
  logic [WIDTH-1:0] add_x_c;
  logic [WIDTH-1:0] add_y_c;
  logic             add_cin_c;
  logic [WIDTH:0]   sum_c;
  logic             is_arith_c;
  logic             is_cmp_c;
  logic [WIDTH-1:0] res_c;
  logic             alu_c_c;
  logic             alu_v_c;
  logic [WIDTH-1:0] acc_next_c;
  logic             last_step_c;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept_c = in_valid && in_ready;

  // Every arithmetic op is an adder x + y + cin; subtracts feed the inverted operand.
  always_comb begin
    add_x_c    = A;
    add_y_c    = B;
    add_cin_c  = 1'b0;
    is_arith_c = 1'b0;
    res_c      = '0;
    case (ALU_OP)
      4'h0, 4'h8: res_c = A & B;
      4'h1, 4'h9: res_c = A ^ B;
      4'h2, 4'hA: begin add_y_c = ~B; add_cin_c = 1'b1; is_arith_c = 1'b1; end
      4'h3:       begin add_x_c = B; add_y_c = ~A; add_cin_c = 1'b1; is_arith_c = 1'b1; end
      4'h4, 4'hB: is_arith_c = 1'b1;
      4'h5:       begin add_cin_c = NZCV[1]; is_arith_c = 1'b1; end
      4'h6:       begin add_y_c = ~B; add_cin_c = NZCV[1]; is_arith_c = 1'b1; end
      4'h7:       begin add_x_c = B; add_y_c = ~A; add_cin_c = NZCV[1]; is_arith_c = 1'b1; end
      4'hC:       res_c = A | B;
      4'hD:       res_c = B;
      4'hE:       res_c = A & ~B;
      default:    res_c = ~B;
    endcase
    sum_c = {1'b0, add_x_c} + {1'b0, add_y_c} + {{WIDTH{1'b0}}, add_cin_c};
    if (is_arith_c) begin
      res_c = sum_c[WIDTH-1:0];
    end
    alu_c_c  = is_arith_c ? sum_c[WIDTH] : shiftCout;
    alu_v_c  = is_arith_c ? ((add_x_c[WIDTH-1] == add_y_c[WIDTH-1]) &&
                             (sum_c[WIDTH-1] != add_x_c[WIDTH-1]))
                          : NZCV[0];
    is_cmp_c = (ALU_OP[3:2] == 2'b10);
  end

  // One shift-add step: accumulate A<<k whenever bit k of B is set.
  always_comb begin
    acc_next_c  = acc + (mul_b[0] ? mul_a : '0);
    last_step_c = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      F         <= '0;
      NZCV      <= 4'b0000;
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      acc       <= '0;
      cnt       <= '0;
      mul_s     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            if (mul) begin
              state     <= MUL;
              mul_a     <= A;
              mul_b     <= B;
              mul_s     <= S;
              acc       <= '0;
              cnt       <= '0;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              F         <= res_c;
              wr_en     <= !is_cmp_c;
              out_valid <= 1'b1;
              if (is_cmp_c || S) begin
                NZCV <= {res_c[WIDTH-1], (res_c == '0), alu_c_c, alu_v_c};
              end
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          acc   <= acc_next_c;
          mul_a <= mul_a << 1;
          mul_b <= mul_b >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_step_c) begin
            state     <= IDLE;
            F         <= acc_next_c;
            wr_en     <= 1'b1;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            // Multiply only defines N and Z; C and V keep their old values.
            if (mul_s) begin
              NZCV[3:2] <= {acc_next_c[WIDTH-1], (acc_next_c == '0)};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboard bench for alu_flag_unit: randomized and directed operations are
// predicted by an arithmetic reference model and checked by a separate monitor.
module tb_alu_flag_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ALU_OP;
  logic        S;
  logic        mul;
  logic        shiftCout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] F;
  logic        wr_en;
  logic [3:0]  NZCV;
  logic        busy;

  alu_flag_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_OP(ALU_OP), .S(S), .mul(mul), .shiftCout(shiftCout),
    .out_valid(out_valid), .out_ready(out_ready), .F(F), .wr_en(wr_en),
    .NZCV(NZCV), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int bp_mode = 1;            // 0 random out_ready, 1 always ready, 2 stalled
  logic [3:0]  m_nzcv = 4'b0000;
  logic [36:0] exp_q[$];      // {wr_en, NZCV, F}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s timed out", name);
  endtask

  // Reference model: plain wide arithmetic on the architectural rules.
  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic s, input logic sc, input logic m,
                                   output logic [31:0] f, output logic we);
    longint unsigned ua, ub, ci, ur;
    longint sa, sb, sr;
    logic c, v;
    bit arith;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = m_nzcv[1] ? 64'd1 : 64'd0;
    arith = 1'b1;
    c = 1'b0;
    v = 1'b0;
    ur = 64'd0;
    sr = 64'sd0;
    f = 32'd0;
    if (m) begin
      ur = ua * ub;
      f = ur[31:0];
      we = 1'b1;
      if (s) m_nzcv[3:2] = {f[31], (f == 32'd0)};
      return;
    end
    case (op)
      4'h2, 4'hA: begin ur = ua - ub; sr = sa - sb; c = (ua >= ub); end
      4'h3:       begin ur = ub - ua; sr = sb - sa; c = (ub >= ua); end
      4'h4, 4'hB: begin ur = ua + ub; sr = sa + sb; c = (ur >= 64'h1_0000_0000); end
      4'h5:       begin ur = ua + ub + ci; sr = sa + sb + longint'(ci); c = (ur >= 64'h1_0000_0000); end
      4'h6:       begin ur = ua - ub - (64'd1 - ci); sr = sa - sb - longint'(64'd1 - ci);
                        c = (ua >= ub + 64'd1 - ci); end
      4'h7:       begin ur = ub - ua - (64'd1 - ci); sr = sb - sa - longint'(64'd1 - ci);
                        c = (ub >= ua + 64'd1 - ci); end
      default:    arith = 1'b0;
    endcase
    if (arith) begin
      f = ur[31:0];
      v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else begin
      case (op)
        4'h0, 4'h8: f = a & b;
        4'h1, 4'h9: f = a ^ b;
        4'hC:       f = a | b;
        4'hD:       f = b;
        4'hE:       f = a & ~b;
        default:    f = ~b;
      endcase
      c = sc;
      v = m_nzcv[0];
    end
    we = !(op inside {4'h8, 4'h9, 4'hA, 4'hB});
    if (!we || s) m_nzcv = {f[31], (f == 32'd0), c, v};
  endfunction

  // Present one request, hold it until accepted, predict on the accept cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic sc, input logic m);
    logic [31:0] f;
    logic we;
    int waited = 0;
    bit done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; ALU_OP = op; A = a; B = b; S = s; shiftCout = sc; mul = m;
    while (!done) begin
      #1;
      if (in_ready) begin
        model_op(op, a, b, s, sc, m, f, we);
        exp_q.push_back({we, m_nzcv, f});
        done = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        mul = 1'b0;
      end else if (++waited > 200) begin
        timeout("issue");
        in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic drain();
    int waited = 0;
    bp_mode = 1;
    while (exp_q.size() != 0 || out_valid) begin
      @(negedge clk);
      if (++waited > 200) begin
        timeout("drain");
        exp_q.delete();
        break;
      end
    end
  endtask

  // Directed check of the currently presented result, taken mid-cycle.
  task automatic expect_now(input string name, input logic [31:0] f, input logic [3:0] nzcv,
                            input logic we);
    @(negedge clk);
    #3;
    check({name, "_out_valid"}, 64'(out_valid), 64'd1);
    check({name, "_F"}, 64'(F), 64'(f));
    check({name, "_NZCV"}, 64'(NZCV), 64'(nzcv));
    check({name, "_wr_en"}, 64'(wr_en), 64'(we));
  endtask

  task automatic mul_latency(input string name);
    int cyc = 0;
    bit stall_ok = 1'b1;
    forever begin
      @(negedge clk);
      #3;
      if (out_valid) break;
      if (!busy || in_ready) stall_ok = 1'b0;
      if (++cyc > 100) break;
    end
    check({name, "_busy_stall"}, 64'(stall_ok), 64'd1);
    check({name, "_latency"}, 64'(cyc), 64'd32);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Consumer back-pressure.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      out_ready = (bp_mode == 1) ? 1'b1 : (bp_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: one transfer per cycle where out_valid and out_ready meet.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 64'(F), 64'hDEAD_0000_0000);
        end else begin
          e = exp_q.pop_front();
          check("sb_F", 64'(F), 64'(e[31:0]));
          check("sb_NZCV", 64'(NZCV), 64'(e[35:32]));
          check("sb_wr_en", 64'(wr_en), 64'(e[36]));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; ALU_OP = '0;
    S = 1'b0; mul = 1'b0; shiftCout = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_F", 64'(F), 64'd0);
    check("reset_NZCV", 64'(NZCV), 64'd0);
    check("reset_valid_we_busy", 64'({out_valid, wr_en, busy}), 64'd0);
    rst_n = 1'b1;

    issue(4'h4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    expect_now("add_ovf", 32'h8000_0000, 4'b1001, 1'b1);

    issue(4'hA, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
    expect_now("cmp_eq", 32'd0, 4'b0110, 1'b0);
    issue(4'hC, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    expect_now("orr_noS", 32'd0, 4'b0110, 1'b1);

    issue(4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
    issue(4'h5, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
    expect_now("adc_b2b", 32'd3, 4'b0000, 1'b1);

    issue(4'hA, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 1'b0);
    expect_now("cmp_cv", 32'h7FFF_FFFF, 4'b0011, 1'b0);
    issue(4'h0, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b1);
    mul_latency("mul_big");
    check("mul_big_F", 64'(F), 64'd0);
    check("mul_big_NZCV", 64'(NZCV), 64'b0111);
    issue(4'h0, 32'd7, 32'd6, 1'b0, 1'b0, 1'b1);
    mul_latency("mul_small");
    check("mul_small_F", 64'(F), 64'd42);

    drain();
    bp_mode = 2;
    issue(4'h2, 32'd3, 32'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_state", 64'({out_valid, wr_en, NZCV, F}), 64'({1'b1, 1'b1, 4'b1000, 32'hFFFF_FFFE}));
    end
    bp_mode = 1;
    @(negedge clk);
    #3;
    check("release_in_ready", 64'(in_ready), 64'd1);

    drain();
    issue(4'h0, 32'($urandom()), 32'($urandom()), 1'b1, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midmul_rst_outputs", 64'({F, NZCV, out_valid, wr_en, busy}), 64'd0);
    check("midmul_rst_idle", 64'(in_ready), 64'd1);
    exp_q.delete();
    m_nzcv = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'h0, 32'h0000_00F0, 32'h0000_003C, 1'b1, 1'b1, 1'b0);
    expect_now("and_after_rst", 32'h0000_0030, 4'b0010, 1'b1);

    drain();
    bp_mode = 0;
    for (int i = 0; i < 150; i++) begin
      issue(4'($urandom_range(0, 15)), rand_val(), rand_val(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
